stack_push_sequencer: RTL and testbench
=======================================

STACK_PUSH_SEQUENCER -- requirements
Module: stack_push_sequencer

Interface
REQ-001 SHALL have parameter FLAG_W, default 3, giving the condition-flag width (Z,N,C); FLAG_W SHALL be at most 16.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port call_req  input  1  CALL in execute; request to push the return PC.
REQ-005 SHALL have port int_req  input  1  interrupt taken; request to push the flags and then the return PC.
REQ-006 SHALL have port pc  input  32  return PC to save.
REQ-007 SHALL have port flags  input  FLAG_W  condition flags to save.
REQ-008 SHALL have port sp_in  input  32  current stack pointer from the register file.
REQ-009 SHALL have port mem_we  output  1  data-memory write enable.
REQ-010 SHALL have port mem_addr  output  32  data-memory word address.
REQ-011 SHALL have port mem_wdata  output  16  data-memory write word.
REQ-012 SHALL have port sp_out  output  32  updated stack pointer.
REQ-013 SHALL have port sp_we  output  1  one-cycle write strobe for sp_out.
REQ-014 SHALL have port stall  output  1  holds fetch and decode while a push sequence is in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse marking the end of a sequence.

Function
REQ-016 SHALL implement the states IDLE, PUSH_FLAGS, PUSH_PC_HI and PUSH_PC_LO.
REQ-017 In IDLE, when int_req=1 at a rising edge, SHALL capture pc, flags and sp_in, and SHALL move to PUSH_FLAGS.
REQ-018 In IDLE, when call_req=1 and int_req=0 at a rising edge, SHALL capture pc and sp_in, and SHALL move to PUSH_PC_HI.
REQ-019 When int_req and call_req are both 1, int_req SHALL win and call_req SHALL NOT be accepted; the caller holds call_req, and it is served after the interrupt sequence.
REQ-020 SHALL ignore requests in any state other than IDLE.
REQ-021 On every edge that leaves a PUSH_* state, SHALL decrement the internal stack pointer (sp_reg) by 1, modulo 2^32; 0 SHALL wrap to 0xFFFFFFFF with no error.
REQ-022 SHALL assert mem_we=1 and drive mem_addr=sp_reg in each PUSH_* state.
REQ-023 SHALL drive mem_wdata as follows: PUSH_FLAGS = flags zero-extended to 16 bits; PUSH_PC_HI = pc[31:16]; PUSH_PC_LO = pc[15:0].
REQ-024 SHALL make the transitions PUSH_FLAGS -> PUSH_PC_HI -> PUSH_PC_LO -> IDLE, each unconditional after one cycle.
REQ-025 SHALL push in the order flags, PC high, PC low, so that the return-pop sequencer recovers PC low, then PC high, then flags.
REQ-026 SHALL assert stall=1 combinationally in the request-accept cycle (IDLE with a request present) and in every PUSH_* state, and SHALL hold stall=0 otherwise.
REQ-027 SHALL pulse done=1 and sp_we=1 for exactly one cycle, in the cycle immediately after leaving PUSH_PC_LO, with sp_out equal to the final sp_reg.
REQ-028 Latency: a CALL SHALL take 2 write cycles and done SHALL follow on the 3rd cycle after acceptance; an interrupt SHALL take 3 write cycles and done SHALL follow on the 4th.
REQ-029 A request present in the same cycle that done=1 SHALL be accepted, so sequences can run back-to-back with no idle gap.
REQ-030 mem_we SHALL never be 1 in IDLE.
REQ-031 When not in a PUSH_* state, mem_addr and mem_wdata SHALL be 0.

Reset
REQ-032 reset=0 SHALL immediately force IDLE and set sp_reg, all captured registers, mem_we, mem_addr, mem_wdata, sp_out, sp_we, done and stall to 0, independent of clk.
REQ-033 Reset asserted mid-sequence SHALL abort the sequence: no further memory writes, no sp_we and no done.
REQ-034 After reset=1 is released, the first rising edge SHALL already evaluate requests.

Verification
REQ-035 Bench SHALL cover: CALL with pc=0x0001_2345, sp_in=0x0000_07FF -> writes (0x7FF, 0x0001), (0x7FE, 0x2345); then done=1, sp_we=1, sp_out=0x7FD; stall high for 3 cycles.
REQ-036 Bench SHALL cover: interrupt with pc=0x0000_0040, flags=3'b101, sp_in=0x7FF -> writes (0x7FF, 0x0005), (0x7FE, 0x0000), (0x7FD, 0x0040); then sp_out=0x7FC.
REQ-037 Bench SHALL cover: call_req=int_req=1 in the same cycle -> interrupt sequence of 3 writes, then the held CALL is accepted in the done cycle with sp_in=0x7FC -> writes at 0x7FC and 0x7FB.
REQ-038 Bench SHALL cover: sp_in=0x0000_0000 with a CALL -> writes at 0x00000000 and 0xFFFFFFFF, sp_out=0xFFFFFFFE.
REQ-039 Bench SHALL cover: reset=0 asserted in PUSH_PC_HI of an interrupt -> outputs 0 within the same cycle, no PUSH_PC_LO write, no done, IDLE after release.
REQ-040 Bench SHALL cover: call_req pulsed while in PUSH_PC_LO and dropped before done -> ignored, no extra writes.

Source files
------------

// File: rtl/stack_push_sequencer.sv
// rtl/stack_push_sequencer.sv - push sequencer that saves flags and return PC on CALL / interrupt
//
// Purpose:
//   Writes the return context onto a downward-growing stack of 16-bit words.
//   An interrupt pushes flags, PC[31:16] and PC[15:0]. A CALL pushes
//   PC[31:16] and PC[15:0]. Each write goes to the current stack pointer,
//   which is then decremented. A one-cycle done/sp_we pulse follows the last
//   write and hands the final stack pointer back to the register file.
//
// Ports:
//   clk        in   system clock, rising-edge active
//   reset      in   asynchronous active-low reset
//   call_req   in   CALL in execute: push return PC
//   int_req    in   interrupt taken: push flags then return PC (wins over call_req)
//   pc         in   [31:0]       return PC to save
//   flags      in   [FLAG_W-1:0] condition flags to save
//   sp_in      in   [31:0]       current stack pointer
//   mem_we     out  data-memory write enable
//   mem_addr   out  [31:0]       data-memory word address
//   mem_wdata  out  [15:0]       data-memory write word
//   sp_out     out  [31:0]       updated stack pointer (valid with sp_we)
//   sp_we      out  one-cycle write strobe for sp_out
//   stall      out  holds fetch/decode while a push sequence is in progress
//   done       out  one-cycle end-of-sequence pulse
module stack_push_sequencer #(
  parameter int FLAG_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              call_req,
  input  logic              int_req,
  input  logic [31:0]       pc,
  input  logic [FLAG_W-1:0] flags,
  input  logic [31:0]       sp_in,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [31:0]       sp_out,
  output logic              sp_we,
  output logic              stall,
  output logic              done
);

  // Flags must fit in one stack word.
  if (FLAG_W < 1 || FLAG_W > 16) begin : g_flag_w_check
    $error("stack_push_sequencer: FLAG_W must be in 1..16");
  end

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PUSH_FLAGS = 2'd1,
    PUSH_PC_HI = 2'd2,
    PUSH_PC_LO = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [31:0]       sp_reg;
  logic [31:0]       pc_reg;
  logic [FLAG_W-1:0] flags_reg;
  logic              done_reg;
  logic [15:0]       flags_ext;

  logic in_push;
  logic accept_int;
  logic accept_call;

  assign in_push     = (state != IDLE);
  // Requests are only sampled in IDLE; the done cycle is an IDLE cycle, which
  // is what lets a waiting request start with no gap.
  assign accept_int  = (state == IDLE) && int_req;
  assign accept_call = (state == IDLE) && call_req && !int_req;

  always_comb begin
    flags_ext = '0;
    flags_ext[FLAG_W-1:0] = flags_reg;
  end

  // State register and captured context
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sp_reg    <= '0;
      pc_reg    <= '0;
      flags_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      state    <= state_nxt;
      done_reg <= (state == PUSH_PC_LO);
      if (accept_int) begin
        pc_reg    <= pc;
        flags_reg <= flags;
        sp_reg    <= sp_in;
      end else if (accept_call) begin
        pc_reg <= pc;
        sp_reg <= sp_in;
      end else if (in_push) begin
        // Post-decrement after every write; wraps 0 -> 0xFFFFFFFF silently.
        sp_reg <= sp_reg - 32'd1;
      end
    end
  end

  // Next state and memory-port outputs
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (int_req) begin
          state_nxt = PUSH_FLAGS;
        end else if (call_req) begin
          state_nxt = PUSH_PC_HI;
        end
      end
      PUSH_FLAGS: begin
        mem_we    = 1'b1;
        mem_addr  = sp_reg;
        mem_wdata = flags_ext;
        state_nxt = PUSH_PC_HI;
      end
      PUSH_PC_HI: begin
        mem_we    = 1'b1;
        mem_addr  = sp_reg;
        mem_wdata = pc_reg[31:16];
        state_nxt = PUSH_PC_LO;
      end
      PUSH_PC_LO: begin
        mem_we    = 1'b1;
        mem_addr  = sp_reg;
        mem_wdata = pc_reg[15:0];
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Stall covers the accept cycle combinationally; gating with reset keeps it
  // low while reset is asserted even if a request is present.
  assign stall  = reset && (in_push || call_req || int_req);
  assign done   = done_reg;
  assign sp_we  = done_reg;
  // sp_reg still holds the final pointer during the done cycle, even if a new
  // request is accepted at the end of that cycle.
  assign sp_out = sp_reg;

endmodule

// File: tb/tb_stack_push_sequencer.sv
// tb/tb_stack_push_sequencer.sv - self-checking bench for stack_push_sequencer
module tb_stack_push_sequencer;

  logic        clk;
  logic        reset;
  logic        call_req;
  logic        int_req;
  logic [31:0] pc;
  logic [2:0]  flags;
  logic [31:0] sp_in;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [31:0] sp_out;
  logic        sp_we;
  logic        stall;
  logic        done;

  int checks;
  int failures;

  stack_push_sequencer #(.FLAG_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .call_req (call_req),
    .int_req  (int_req),
    .pc       (pc),
    .flags    (flags),
    .sp_in    (sp_in),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .sp_out   (sp_out),
    .sp_we    (sp_we),
    .stall    (stall),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bus activity for one future cycle.
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [15:0] data;
    logic        dn;
    logic [31:0] sp;
  } rec_t;

  rec_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_rec(input logic we, input logic [31:0] a, input logic [15:0] d,
                          input logic dn, input logic [31:0] s);
    rec_t r;
    r.we = we; r.addr = a; r.data = d; r.dn = dn; r.sp = s;
    exp_q.push_back(r);
  endtask

  // Reference: an accepted request becomes a list of writes at sp, sp-1, ...
  // followed by one done cycle reporting the pointer below the last write.
  task automatic model_accept(input bit is_int);
    logic [31:0] s;
    s = sp_in;
    if (is_int) begin
      push_rec(1'b1, s, {13'b0, flags}, 1'b0, 32'h0);
      s = s - 32'd1;
    end
    push_rec(1'b1, s, pc[31:16], 1'b0, 32'h0);
    s = s - 32'd1;
    push_rec(1'b1, s, pc[15:0], 1'b0, 32'h0);
    s = s - 32'd1;
    push_rec(1'b0, 32'h0, 16'h0, 1'b1, s);
  endtask

  // One clock cycle: inputs are already driven; check at negedge, advance model,
  // then return 1 time unit after the next rising edge.
  task automatic step();
    rec_t cur;
    bit   idle_now;
    bit   req;
    @(negedge clk);
    if (exp_q.size() > 0) cur = exp_q.pop_front();
    else begin
      cur.we = 1'b0; cur.addr = 32'h0; cur.data = 16'h0; cur.dn = 1'b0; cur.sp = 32'h0;
    end
    idle_now = !cur.we;
    req      = reset && (call_req || int_req);
    chk("mem_we",    {31'b0, mem_we}, {31'b0, cur.we});
    chk("mem_addr",  mem_addr, cur.addr);
    chk("mem_wdata", {16'b0, mem_wdata}, {16'b0, cur.data});
    chk("done",      {31'b0, done}, {31'b0, cur.dn});
    chk("sp_we",     {31'b0, sp_we}, {31'b0, cur.dn});
    chk("stall",     {31'b0, stall}, {31'b0, cur.we || (idle_now && req)});
    if (cur.dn) chk("sp_out", sp_out, cur.sp);
    if (idle_now && reset) begin
      if (int_req) model_accept(1'b1);
      else if (call_req) model_accept(1'b0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    call_req = 1'b0;
    int_req  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},    {31'b0, mem_we}, 32'h0);
    chk({tag, "_addr"},  mem_addr, 32'h0);
    chk({tag, "_wdata"}, {16'b0, mem_wdata}, 32'h0);
    chk({tag, "_sp_out"}, sp_out, 32'h0);
    chk({tag, "_sp_we"}, {31'b0, sp_we}, 32'h0);
    chk({tag, "_done"},  {31'b0, done}, 32'h0);
    chk({tag, "_stall"}, {31'b0, stall}, 32'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    call_req = 1'b0;
    int_req  = 1'b0;
    pc       = 32'h0;
    flags    = 3'b0;
    sp_in    = 32'h0;

    // Reset state, with a request present to show stall stays low in reset
    #12;
    call_req = 1'b1;
    #1;
    chk_all_zero("reset");
    call_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // CALL, pc=0x00012345, sp=0x7FF
    pc = 32'h0001_2345; sp_in = 32'h0000_07FF; call_req = 1'b1;
    step();
    idle_inputs();
    step();
    step();
    chk("call_done_now", {31'b0, done}, 32'h1);
    chk("call_sp_out",   sp_out, 32'h7FD);
    step();
    step();

    // Interrupt, pc=0x40, flags=101, sp=0x7FF
    pc = 32'h0000_0040; flags = 3'b101; sp_in = 32'h7FF; int_req = 1'b1;
    step();
    idle_inputs();
    repeat (3) step();
    chk("int_sp_out", sp_out, 32'h7FC);
    step();

    // Simultaneous int and call; call held and served in the done cycle
    pc = 32'h0000_1234; flags = 3'b011; sp_in = 32'h7FF;
    int_req = 1'b1; call_req = 1'b1;
    step();
    int_req = 1'b0; sp_in = 32'h7FC; pc = 32'h0000_5678;
    repeat (3) step();
    chk("b2b_done", {31'b0, done}, 32'h1);
    step();
    chk("b2b_addr0", mem_addr, 32'h7FC);
    call_req = 1'b0;
    step();
    chk("b2b_addr1", mem_addr, 32'h7FB);
    step();
    step();

    // Stack pointer wrap
    pc = 32'hDEAD_BEEF; sp_in = 32'h0; call_req = 1'b1;
    step();
    idle_inputs();
    chk("wrap_addr0", mem_addr, 32'h0);
    step();
    chk("wrap_addr1", mem_addr, 32'hFFFF_FFFF);
    step();
    chk("wrap_sp_out", sp_out, 32'hFFFF_FFFE);
    step();

    // Reset asserted in PUSH_PC_HI of an interrupt
    pc = 32'h0000_0ABC; flags = 3'b110; sp_in = 32'h100; int_req = 1'b1;
    step();
    idle_inputs();
    step();
    chk("pre_rst_hi_addr", mem_addr, 32'hFF);
    reset = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    exp_q.delete();
    step();
    step();
    #2;
    reset = 1'b1;
    repeat (4) step();

    // call_req pulsed during PUSH_PC_LO is ignored
    pc = 32'h0000_9999; sp_in = 32'h200; call_req = 1'b1;
    step();
    call_req = 1'b0;
    step();
    call_req = 1'b1;
    step();
    call_req = 1'b0;
    repeat (3) step();

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      call_req = ($urandom_range(0, 3) == 0);
      int_req  = ($urandom_range(0, 5) == 0);
      pc       = $urandom;
      flags    = 3'($urandom_range(0, 7));
      sp_in    = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      step();
    end
    idle_inputs();
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
